// File: rtl/tx_fifo_streamer_if.sv
// Byte stream toward the USB transmit path: registered data with a valid/ready handshake.
interface tx_fifo_streamer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] txByte;
    logic                  txValid;
    logic                  txReady;

    modport master (output txByte, output txValid, input txReady);
    modport slave  (input txByte, input txValid, output txReady);
endinterface

// File: rtl/tx_fifo_streamer.sv
// Read-side controller for the dual-clock byte FIFO: drains up to a requested number of
// bytes into a valid/ready stream, ending each packet with a done pulse and a byte count.
module tx_fifo_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pktStart,
    input  logic [CNT_WIDTH-1:0]  pktMaxLen,
    input  logic                  pktAbort,
    input  logic                  fifoEmpty,
    input  logic [DATA_WIDTH-1:0] fifoDataIn,
    output logic                  fifoREn,
    tx_fifo_streamer_if.master    tx,
    output logic                  busy,
    output logic                  pktDone,
    output logic [CNT_WIDTH-1:0]  byteCount
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD_PULSE,
        RD_CAPT,
        SEND,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  limit_q, limit_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        limit_d   = limit_q;
        count_d   = count_q;
        tx_byte_d = tx_byte_q;

        unique case (state_q)
            IDLE: begin
                if (pktStart) begin
                    limit_d = pktMaxLen;
                    count_d = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // CHECK is at least three cycles after the last read strobe, so fifoEmpty is current.
                if (fifoEmpty || (count_q == limit_q)) state_d = DONE;
                else                                   state_d = RD_PULSE;
            end
            RD_PULSE: state_d = RD_CAPT;
            RD_CAPT: begin
                tx_byte_d = fifoDataIn;
                count_d   = count_q + CNT_WIDTH'(1);
                state_d   = SEND;
            end
            SEND: begin
                if (tx.txReady) state_d = CHECK;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // An abort wins over everything, including a capture in flight, so the count only
        // reflects bytes that already reached the stream register.
        if (pktAbort && (state_q != IDLE)) begin
            state_d   = IDLE;
            count_d   = count_q;
            tx_byte_d = tx_byte_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
        if (rst) begin
            state_q   <= IDLE;
            limit_q   <= '0;
            count_q   <= '0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            count_q   <= count_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    // Strobes decode straight from the state register: one cycle per state visit.
    assign fifoREn    = (state_q == RD_PULSE);
    assign tx.txValid = (state_q == SEND);
    assign tx.txByte  = tx_byte_q;
    assign busy       = (state_q != IDLE);
    assign pktDone    = (state_q == DONE);
    assign byteCount  = count_q;

endmodule

// File: doc/tx_fifo_streamer.md
# tx_fifo_streamer

Single-clock read-side controller for the dual-clock byte FIFO. It drains up to a requested number of bytes from the FIFO's read port and presents them one at a time on a valid/ready byte stream toward the USB transmit path. It ends each packet with a done pulse and the transferred byte count. It sits in the FIFO's read-clock domain and respects the FIFO's read-strobe rules: a read happens only on a rising edge of the read enable, and the empty flag lags a read by one cycle.

## Interface
- DATA_WIDTH, 8, width of FIFO data and stream byte
- CNT_WIDTH, 10, width of packet length and byte count (max packet 2^CNT_WIDTH-1 = 1023)

Ports:
- clk  in  1  clock; same clock as the FIFO read side
- rst  in  1  reset; one clock, reset is synchronous and active-high
- pktStart  in  1  start request; sampled only in IDLE
- pktMaxLen  in  CNT_WIDTH  byte limit; latched when pktStart is accepted
- pktAbort  in  1  abandon the current packet; go to IDLE, no pktDone
- fifoEmpty  in  1  FIFO empty flag
- fifoDataIn  in  DATA_WIDTH  FIFO dataOut
- fifoREn  out  1  FIFO read strobe; single-cycle pulse
- txByte  out  DATA_WIDTH  stream data, registered
- txValid  out  1  stream valid
- txReady  in  1  stream ready from the consumer
- busy  out  1  high in every state except IDLE
- pktDone  out  1  one-cycle pulse at packet end
- byteCount  out  CNT_WIDTH  bytes delivered in the current or last packet; held until the next accepted start

## Operation
States: IDLE, CHECK, RD_PULSE, RD_CAPT, SEND, DONE.
- IDLE
  - pktStart=1: latch limit=pktMaxLen, clear byteCount, go to CHECK.
  - pktStart=0: stay in IDLE.
- CHECK
  - fifoEmpty=1 or byteCount==limit: go to DONE.
  - Otherwise: go to RD_PULSE.
- RD_PULSE: fifoREn=1 for this cycle only; go to RD_CAPT.
- RD_CAPT: fifoREn=0; at the end of the cycle, txByte<=fifoDataIn and byteCount<=byteCount+1; go to SEND.
- SEND: txValid=1, txByte held stable.
  - txValid&&txReady: the byte is consumed; go to CHECK.
  - Otherwise: stay in SEND.
- DONE: pktDone=1; go to IDLE.
- pktAbort=1 in any non-IDLE state: next state is IDLE.
  - fifoREn and txValid drop on the next cycle.
  - No pktDone.
  - byteCount keeps the bytes already captured.
  - pktAbort has priority over all other transitions.
- pktStart outside IDLE is ignored; it is not queued.
- limit=0: CHECK goes straight to DONE. No FIFO read, byteCount=0, pktDone pulses.
- byteCount never exceeds limit. It never wraps, because limit ≤ 2^CNT_WIDTH-1.
- fifoREn is only ever high in RD_PULSE.

## Timing
- Reset values: fifoREn=0, txValid=0, txByte=0, busy=0, pktDone=0, byteCount=0, state IDLE. Reset has priority over pktAbort and pktStart.
- Read sequence, with the fifoREn pulse in cycle N:
  - FIFO dataOut is valid in cycle N+1 and is captured at the end of N+1.
  - txValid is high from N+2.
  - fifoEmpty reflects the read from N+2.
  - The earliest CHECK is N+3, so fifoEmpty is never sampled stale.
- fifoREn is low for at least 3 cycles between pulses. This guarantees a rising edge, so the FIFO's edge detector accepts each read.
- Throughput with txReady held at 1: 4 cycles per byte (CHECK, RD_PULSE, RD_CAPT, SEND).
- Start and end latency:
  - pktStart in cycle S: busy from S+1, first fifoREn at S+2.
  - Empty FIFO at start: pktDone at S+2.
- pktDone is high in the cycle after the final CHECK. byteCount is final and stable in that cycle.
- txByte does not change while txValid=1 and txReady=0.

## Test plan
- FIFO preloaded with 0x11,0x22,0x33; pktMaxLen=8; txReady=1 → bytes 11,22,33 in order, 4 cycles apart; pktDone with byteCount=3; exactly 3 fifoREn pulses.
- FIFO holds 10 bytes; pktMaxLen=4 → exactly 4 bytes streamed, pktDone with byteCount=4; 6 bytes remain in the FIFO (numElementsInFifo=6).
- Empty FIFO; pktStart in cycle S → no fifoREn; pktDone at S+2 with byteCount=0. Also pktMaxLen=0 with a non-empty FIFO → same response.
- txReady held low 5 cycles during SEND → txValid stays high and txByte stays stable; no fifoREn while stalled; resumes after txReady=1.
- pktAbort during SEND of byte 2 → IDLE next cycle; no pktDone; byteCount=2. rst asserted in RD_PULSE → all outputs at reset values the next cycle.
- Back-to-back: pktStart again the cycle after pktDone → accepted; byteCount restarts from 0; ≥3 low cycles between fifoREn pulses checked across the whole run.
